// File: rtl/fifo_rst_seq.sv
// Front FIFO reset sequencer: on each accepted frame-start edge it pulses the
// buffer reset, waits a guard interval, then opens the data gate.
module fifo_rst_seq #(
   parameter int unsigned RST_CYCLES   = 4,
   parameter int unsigned GUARD_CYCLES = 8,
   parameter int unsigned EDGE_MODE    = 0,
   parameter int unsigned DATA_W       = 16,
   parameter int unsigned ERR_W        = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_en,
   input  logic              i_fval,
   input  logic              i_dval,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_rst_buf,
   output logic              o_buf_ready,
   output logic              o_dval,
   output logic [DATA_W-1:0] o_data,
   output logic              o_dval_err,
   output logic [ERR_W-1:0]  o_err_cnt
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_RST    = 2'd1;
   localparam logic [1:0] S_GUARD  = 2'd2;
   localparam logic [1:0] S_ACTIVE = 2'd3;

   // GUARD_LD wraps when GUARD_CYCLES is 0, but is never loaded in that case
   localparam logic [7:0] RST_LD   = 8'(RST_CYCLES - 1);
   localparam logic [7:0] GUARD_LD = 8'(GUARD_CYCLES - 1);

   logic [1:0] state;
   logic [7:0] cnt;
   logic       fval_d;
   logic       fedge;
   logic       in_win;

   always_comb begin
      if (EDGE_MODE != 0)
         fedge = i_en & fval_d & ~i_fval;
      else
         fedge = i_en & ~fval_d & i_fval;
      in_win = (state == S_RST) || (state == S_GUARD);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         cnt    <= '0;
         fval_d <= 1'b0;
      end else begin
         fval_d <= i_fval;
         if (fedge) begin
            state <= S_RST;
            cnt   <= RST_LD;
         end else begin
            case (state)
               S_RST: begin
                  if (cnt == '0) begin
                     if (GUARD_CYCLES == 0) begin
                        state <= S_ACTIVE;
                     end else begin
                        state <= S_GUARD;
                        cnt   <= GUARD_LD;
                     end
                  end else begin
                     cnt <= cnt - 8'd1;
                  end
               end
               S_GUARD: begin
                  if (cnt == '0)
                     state <= S_ACTIVE;
                  else
                     cnt <= cnt - 8'd1;
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_data <= '0;
         o_dval <= 1'b0;
      end else begin
         o_data <= i_data;
         o_dval <= i_dval & (state == S_ACTIVE) & ~fedge;
      end
   end

   // Counter steps only on the flag's rising transition: one count per frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_dval_err <= 1'b0;
         o_err_cnt  <= '0;
      end else if (fedge) begin
         o_dval_err <= 1'b0;
      end else if (i_dval && in_win) begin
         o_dval_err <= 1'b1;
         if (!o_dval_err && (o_err_cnt != '1))
            o_err_cnt <= o_err_cnt + ERR_W'(1);
      end
   end

   assign o_rst_buf   = (state == S_RST);
   assign o_buf_ready = (state == S_ACTIVE);

endmodule

// File: tb/tb_fifo_rst_seq.sv
// Bench for fifo_rst_seq: three configurations on shared stimulus, each checked
// against a model that derives phase from cycles elapsed since the last edge.
module tb_fifo_rst_seq;

   localparam int N = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        fval = 1'b0;
   logic        dval = 1'b0;
   logic [15:0] data = '0;

   logic        rb0, rdy0, dv0, er0, rb1, rdy1, dv1, er1, rb2, rdy2, dv2, er2;
   logic [15:0] d0, d1, d2;
   logic [7:0]  c0, c2;
   logic [1:0]  c1;
   logic [27:0] obs [N];

   always #5 clk = ~clk;

   fifo_rst_seq #(.RST_CYCLES(4), .GUARD_CYCLES(8), .EDGE_MODE(0), .DATA_W(16), .ERR_W(8)) u0 (
      .clk(clk), .rst_n(rst_n), .i_en(en), .i_fval(fval), .i_dval(dval), .i_data(data),
      .o_rst_buf(rb0), .o_buf_ready(rdy0), .o_dval(dv0), .o_data(d0), .o_dval_err(er0), .o_err_cnt(c0));
   fifo_rst_seq #(.RST_CYCLES(1), .GUARD_CYCLES(0), .EDGE_MODE(0), .DATA_W(16), .ERR_W(2)) u1 (
      .clk(clk), .rst_n(rst_n), .i_en(en), .i_fval(fval), .i_dval(dval), .i_data(data),
      .o_rst_buf(rb1), .o_buf_ready(rdy1), .o_dval(dv1), .o_data(d1), .o_dval_err(er1), .o_err_cnt(c1));
   fifo_rst_seq #(.RST_CYCLES(3), .GUARD_CYCLES(2), .EDGE_MODE(1), .DATA_W(16), .ERR_W(8)) u2 (
      .clk(clk), .rst_n(rst_n), .i_en(en), .i_fval(fval), .i_dval(dval), .i_data(data),
      .o_rst_buf(rb2), .o_buf_ready(rdy2), .o_dval(dv2), .o_data(d2), .o_dval_err(er2), .o_err_cnt(c2));

   // {rst_buf, ready, dval, err, cnt[7:0], data[15:0]}
   always_comb begin
      obs[0] = {rb0, rdy0, dv0, er0, c0, d0};
      obs[1] = {rb1, rdy1, dv1, er1, 6'd0, c1, d1};
      obs[2] = {rb2, rdy2, dv2, er2, c2, d2};
   end

   int r_cyc [N] = '{4, 1, 3};
   int g_cyc [N] = '{8, 0, 2};
   int e_mode [N] = '{0, 0, 1};
   int c_max [N] = '{255, 3, 255};

   int          total = 0;
   int          bad = 0;
   int          k;
   int          last_n [N];
   bit          merr [N];
   int          mcnt [N];
   bit          mdval [N];
   bit          mprev;
   logic [15:0] mdata;

   // 0 idle, 1 reset pulse, 2 guard, 3 active; d = clocks since the edge clock
   function automatic int phase(int i, int d);
      if (last_n[i] < 0) return 0;
      if (d < r_cyc[i]) return 1;
      if (d < r_cyc[i] + g_cyc[i]) return 2;
      return 3;
   endfunction

   function automatic logic [27:0] expv(int i);
      int ph;
      ph = phase(i, k - last_n[i]);
      return {ph == 1, ph == 3, mdval[i], merr[i], 8'(mcnt[i]), mdata};
   endfunction

   function automatic void model_reset();
      k = 0;
      mprev = 1'b0;
      mdata = '0;
      for (int i = 0; i < N; i++) begin
         last_n[i] = -1;
         merr[i] = 1'b0;
         mcnt[i] = 0;
         mdval[i] = 1'b0;
      end
   endfunction

   function automatic void model_step();
      int ph;
      bit e;
      k++;
      for (int i = 0; i < N; i++) begin
         ph = phase(i, k - 1 - last_n[i]);
         e = en && ((e_mode[i] != 0) ? (mprev && !fval) : (!mprev && fval));
         mdval[i] = dval && (ph == 3) && !e;
         if (e) merr[i] = 1'b0;
         else if (dval && (ph == 1 || ph == 2)) begin
            if (!merr[i] && mcnt[i] < c_max[i]) mcnt[i]++;
            merr[i] = 1'b1;
         end
         if (e) last_n[i] = k;
      end
      mprev = fval;
      mdata = data;
   endfunction

   task automatic cyc(input bit f, input bit dv);
      fval = f;
      dval = dv;
      data = 16'($urandom);
      @(posedge clk);
      if (rst_n) model_step();
      @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      for (int i = 0; i < N; i++) begin
         total++;
         if (obs[i] !== 28'd0) begin
            bad++;
            $display("FAIL reset_state dut%0d got=%h exp=%h", i, obs[i], 28'd0);
         end
      end
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         cyc(1'b0, 1'b0);
         for (int i = 0; i < N; i++) begin
            total++;
            if (obs[i] !== expv(i)) begin
               bad++;
               $display("FAIL reset_idle dut%0d k=%0d got=%h exp=%h", i, k, obs[i], expv(i));
            end
         end
      end
   endtask

   task automatic test_single_frame();
      int rst0 = 0, rst1 = 0, rdy0_at = -1, rdy1_at = -1, dv0_at = -1;
      en = 1'b1;
      repeat (4) cyc(1'b0, 1'b0);
      for (int off = 0; off < 30; off++) begin
         cyc(1'b1, off >= 20);
         if (obs[0][27]) rst0++;
         if (obs[1][27]) rst1++;
         if (obs[0][26] && rdy0_at < 0) rdy0_at = off;
         if (obs[1][26] && rdy1_at < 0) rdy1_at = off;
         if (obs[0][25] && dv0_at < 0) dv0_at = off;
         for (int i = 0; i < N; i++) begin
            total++;
            if (obs[i] !== expv(i)) begin
               bad++;
               $display("FAIL single_frame dut%0d off=%0d got=%h exp=%h", i, off, obs[i], expv(i));
            end
         end
      end
      total += 5;
      if (rst0 != 4) begin bad++; $display("FAIL pulse_len_def got=%0d exp=4", rst0); end
      if (rdy0_at != 12) begin bad++; $display("FAIL ready_at_def got=%0d exp=12", rdy0_at); end
      if (rst1 != 1) begin bad++; $display("FAIL pulse_len_r1 got=%0d exp=1", rst1); end
      if (rdy1_at != 1) begin bad++; $display("FAIL ready_at_r1 got=%0d exp=1", rdy1_at); end
      if (dv0_at != 20) begin bad++; $display("FAIL first_dval got=%0d exp=20", dv0_at); end
   endtask

   task automatic test_short_gap();
      int dv_seen = 0;
      repeat (2) cyc(1'b0, 1'b0);
      for (int off = 0; off < 13; off++) begin
         cyc(1'b1, off == 6 || off == 7);
         if (obs[0][25]) dv_seen++;
         for (int i = 0; i < N; i++) begin
            total++;
            if (obs[i] !== expv(i)) begin
               bad++;
               $display("FAIL short_gap dut%0d off=%0d got=%h exp=%h", i, off, obs[i], expv(i));
            end
         end
      end
      total += 3;
      if (dv_seen != 0) begin bad++; $display("FAIL gap_dval_gated got=%0d exp=0", dv_seen); end
      if (obs[0][24] !== 1'b1) begin bad++; $display("FAIL gap_err_flag got=%b exp=1", obs[0][24]); end
      if (obs[0][23:16] !== 8'd1) begin bad++; $display("FAIL gap_err_cnt got=%0d exp=1", obs[0][23:16]); end
      cyc(1'b0, 1'b0);
      cyc(1'b1, 1'b0);
      total += 2;
      if (obs[0][24] !== 1'b0) begin bad++; $display("FAIL gap_err_clear got=%b exp=0", obs[0][24]); end
      if (obs[0][23:16] !== 8'd1) begin bad++; $display("FAIL gap_cnt_hold got=%0d exp=1", obs[0][23:16]); end
   endtask

   task automatic test_restart();
      int rst0 = 0, rdy0_at = -1;
      cyc(1'b0, 1'b0);
      for (int off = 0; off < 30; off++) begin
         cyc(!(off == 5 || off == 6), 1'b0);
         if (obs[0][27]) rst0++;
         if (obs[0][26] && rdy0_at < 0) rdy0_at = off;
         for (int i = 0; i < N; i++) begin
            total++;
            if (obs[i] !== expv(i)) begin
               bad++;
               $display("FAIL restart dut%0d off=%0d got=%h exp=%h", i, off, obs[i], expv(i));
            end
         end
      end
      total += 2;
      if (rst0 != 8) begin bad++; $display("FAIL restart_pulses got=%0d exp=8", rst0); end
      if (rdy0_at != 19) begin bad++; $display("FAIL restart_ready got=%0d exp=19", rdy0_at); end
   endtask

   task automatic test_en_gate();
      int rst_any = 0;
      en = 1'b0;
      for (int off = 0; off < 20; off++) begin
         cyc(off[1], 1'($urandom));
         if (obs[0][27] || obs[1][27] || obs[2][27]) rst_any++;
         for (int i = 0; i < N; i++) begin
            total++;
            if (obs[i] !== expv(i)) begin
               bad++;
               $display("FAIL en_gate dut%0d off=%0d got=%h exp=%h", i, off, obs[i], expv(i));
            end
         end
      end
      total++;
      if (rst_any != 0) begin bad++; $display("FAIL en_no_pulse got=%0d exp=0", rst_any); end
      en = 1'b1;
      cyc(1'b0, 1'b0);
      cyc(1'b1, 1'b0);
      en = 1'b0;
      for (int off = 0; off < 15; off++) begin
         cyc(1'b1, 1'($urandom));
         for (int i = 0; i < N; i++) begin
            total++;
            if (obs[i] !== expv(i)) begin
               bad++;
               $display("FAIL en_no_abort dut%0d off=%0d got=%h exp=%h", i, off, obs[i], expv(i));
            end
         end
      end
      total++;
      if (obs[0][26] !== 1'b1) begin bad++; $display("FAIL en_completes got=%b exp=1", obs[0][26]); end
   endtask

   task automatic test_async_reset();
      en = 1'b1;
      cyc(1'b0, 1'b0);
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      for (int i = 0; i < N; i++) begin
         total++;
         if (obs[i] !== 28'd0) begin
            bad++;
            $display("FAIL async_reset dut%0d got=%h exp=%h", i, obs[i], 28'd0);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int off = 0; off < 6; off++) begin
         cyc(1'b1, 1'b0);
         for (int i = 0; i < N; i++) begin
            total++;
            if (obs[i] !== expv(i)) begin
               bad++;
               $display("FAIL post_reset dut%0d off=%0d got=%h exp=%h", i, off, obs[i], expv(i));
            end
         end
         if (off == 0) begin
            total += 2;
            if (obs[0][27] !== 1'b1) begin bad++; $display("FAIL release_edge got=%b exp=1", obs[0][27]); end
            if (obs[2][27] !== 1'b0) begin bad++; $display("FAIL release_fall got=%b exp=0", obs[2][27]); end
         end
      end
   endtask

   task automatic test_saturation();
      en = 1'b1;
      for (int fr = 0; fr < 5; fr++) begin
         for (int s = 0; s < 3; s++) begin
            cyc(s != 0, s == 2);
            for (int i = 0; i < N; i++) begin
               total++;
               if (obs[i] !== expv(i)) begin
                  bad++;
                  $display("FAIL saturation dut%0d fr=%0d got=%h exp=%h", i, fr, obs[i], expv(i));
               end
            end
         end
      end
      total++;
      if (obs[1][23:16] !== 8'd3) begin bad++; $display("FAIL sat_cnt got=%0d exp=3", obs[1][23:16]); end
   endtask

   task automatic test_random();
      bit f = 1'b0;
      for (int c = 0; c < 600; c++) begin
         en = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 11) == 0) f = !f;
         cyc(f, 1'($urandom));
         for (int i = 0; i < N; i++) begin
            total++;
            if (obs[i] !== expv(i)) begin
               bad++;
               $display("FAIL random dut%0d c=%0d got=%h exp=%h", i, c, obs[i], expv(i));
            end
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single_frame();
      test_short_gap();
      test_restart();
      test_en_gate();
      test_async_reset();
      test_saturation();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
